// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Wide enough for the double-width product; callers truncate with a cast.
    localparam int NEG_W = 128;
    typedef logic [NEG_W-1:0] neg_t;

    function automatic neg_t cond_negate(input neg_t value, input logic negate);
        return negate ? (~value + neg_t'(1)) : value;
    endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Divide-by-zero and signed-overflow detection with their architectural results,
// for full-width or word (low-half, sign-extended) operation.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            i_func3,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_special,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int HW = DATA_WIDTH / 2;

    logic                  is_div;
    logic                  is_signed;
    logic                  is_rem;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] most_neg;

    always_comb begin
        is_div    = i_func3[2];
        is_signed = ~i_func3[0];
        is_rem    = i_func3[1];
        if (i_word) begin
            dividend = {{HW{i_rs1_data[HW-1]}}, i_rs1_data[HW-1:0]};
            most_neg = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
            div_zero = (i_rs2_data[HW-1:0] == '0);
            overflow = (i_rs1_data[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                    && (i_rs2_data[HW-1:0] == '1);
        end else begin
            dividend = i_rs1_data;
            most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            div_zero = (i_rs2_data == '0);
            overflow = (i_rs1_data == most_neg) && (i_rs2_data == '1);
        end

        o_special = is_div && (div_zero || (is_signed && overflow));
        o_result  = '0;
        if (div_zero) begin
            o_result = is_rem ? dividend : '1;
        end else if (overflow) begin
            o_result = is_rem ? '0 : most_neg;
        end
    end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_WORD_OPS_EN to enable the RV64 *W variants selected by i_word.
module exec_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_flush,
    input  logic [2:0]            i_func3,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_stall,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int W   = DATA_WIDTH;
    localparam int HW  = DATA_WIDTH / 2;
    localparam int DW2 = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_FULL = CNT_WIDTH'(W - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(HW - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           func3_q, func3_d;
    logic                 word_q, word_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [W-1:0]         opa_q, opa_d;
    logic [W-1:0]         opb_q, opb_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [DW2-1:0]       acc_q, acc_d;
    logic [W-1:0]         result_q, result_d;
    logic                 done_q, done_d;

    logic word_en;
`ifdef MULDIV_WORD_OPS_EN
    assign word_en = i_word;
`else
    logic word_unused;
    assign word_en     = 1'b0;
    assign word_unused = i_word;
`endif

    logic         spec_hit;
    logic [W-1:0] spec_result;

    muldiv_special_case #(.DATA_WIDTH(W)) u_special (
        .i_func3    (i_func3),
        .i_word     (word_en),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_special  (spec_hit),
        .o_result   (spec_result)
    );

    // NOTE: synchronous reset clears the datapath registers too, so an aborted
    // operation leaves no stale operands, flags or result behind.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            word_q   <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            word_q   <= word_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = spec_hit ? DONE : CALC;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (word_q ? LAST_WORD : LAST_FULL)) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Operand preparation for the instruction currently presented.
    logic         in_mul, in_signed_a, in_signed_b, in_neg_a, in_neg_b;
    logic [W-1:0] ext_a, ext_b, abs_a, abs_b, first_shift;

    always_comb begin
        in_mul      = ~i_func3[2];
        in_signed_a = (i_func3 == F3_MULH) || (i_func3 == F3_MULHSU)
                   || (i_func3 == F3_DIV)  || (i_func3 == F3_REM);
        in_signed_b = (i_func3 == F3_MULH) || (i_func3 == F3_DIV) || (i_func3 == F3_REM);
        ext_a       = i_rs1_data;
        ext_b       = i_rs2_data;
        if (word_en) begin
            // Word multiplies keep only the low half, so they run unsigned.
            in_signed_a = in_signed_a && !in_mul;
            in_signed_b = in_signed_b && !in_mul;
            ext_a = {{HW{in_signed_a & i_rs1_data[HW-1]}}, i_rs1_data[HW-1:0]};
            ext_b = {{HW{in_signed_b & i_rs2_data[HW-1]}}, i_rs2_data[HW-1:0]};
        end
        in_neg_a    = in_signed_a & ext_a[W-1];
        in_neg_b    = in_signed_b & ext_b[W-1];
        abs_a       = W'(cond_negate(neg_t'(ext_a), in_neg_a));
        abs_b       = W'(cond_negate(neg_t'(ext_b), in_neg_b));
        first_shift = in_mul ? abs_b : abs_a;
        if (word_en) begin
            first_shift = first_shift << HW;
        end
    end

    // One iteration step and the sign/half fix-up of the finished value.
    logic [W:0]     rem_shift, trial;
    logic [DW2-1:0] prod;
    logic [W-1:0]   quo, rem, fix_full, fix_result;

    always_comb begin
        rem_shift = {acc_q[W-1:0], shift_q[W-1]};
        trial     = rem_shift - {1'b0, opb_q};
        prod      = DW2'(cond_negate(neg_t'(acc_q), sign_a_q ^ sign_b_q));
        quo       = W'(cond_negate(neg_t'(shift_q), sign_a_q ^ sign_b_q));
        rem       = W'(cond_negate(neg_t'(acc_q[W-1:0]), sign_a_q));
        if (!func3_q[2]) begin
            fix_full = (func3_q == F3_MUL || word_q) ? prod[W-1:0] : prod[DW2-1:W];
        end else begin
            fix_full = func3_q[1] ? rem : quo;
        end
        fix_result = word_q ? {{HW{fix_full[HW-1]}}, fix_full[HW-1:0]} : fix_full;
    end

    always_comb begin
        func3_d  = func3_q;
        word_d   = word_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (state_q == IDLE && i_start && !i_flush) begin
            func3_d  = i_func3;
            word_d   = word_en;
            sign_a_d = in_neg_a;
            sign_b_d = in_neg_b;
            opa_d    = abs_a;
            opb_d    = abs_b;
            shift_d  = first_shift;
            acc_d    = '0;
        end else if (state_q == CALC) begin
            if (!func3_q[2]) begin
                acc_d   = {acc_q[DW2-2:0], 1'b0} + (shift_q[W-1] ? {{W{1'b0}}, opa_q} : '0);
                shift_d = shift_q << 1;
            end else begin
                acc_d   = {{W{1'b0}}, trial[W] ? rem_shift[W-1:0] : trial[W-1:0]};
                shift_d = {shift_q[W-2:0], ~trial[W]};
            end
        end

        if (state_d == DONE) begin
            result_d = (state_q == FIX) ? fix_result : spec_result;
        end
        done_d = (state_d == DONE);
    end

    always_comb begin
        o_done   = done_q;
        o_result = result_q;
        o_busy   = (state_q == CALC) || (state_q == FIX);
        o_stall  = i_start & ~done_q;
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Self-checking bench for exec_muldiv_unit: expected results are queued at issue
// and compared by a monitor whenever o_done is seen.
`timescale 1ns/1ps
module tb_exec_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W           = 64;
    localparam int LAT_FULL    = W + 1;      // clock edges after the sampling edge until o_done shows
    localparam int LAT_WORD    = W / 2 + 1;
    localparam int LAT_SPECIAL = 0;
    localparam int TIMEOUT     = 200;

    logic         clk = 1'b0;
    logic         rst, start, flush, word;
    logic [2:0]   func3;
    logic [W-1:0] rs1, rs2;
    logic         stall, busy, done;
    logic [W-1:0] result;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    string        mon_tag;
    logic [W-1:0] mon_exp;
    logic [W-1:0] prev_result;
    logic [2:0]   rf3;
    logic [W-1:0] ra, rb;

    exec_muldiv_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_flush    (flush),
        .i_func3    (func3),
        .i_word     (word),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .o_stall    (stall),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb, ua, ub, p;
        logic signed [W-1:0]   sa64, sb64, qs, rs;
        logic [W-1:0]          min_neg, res;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        sa64 = a;
        sb64 = b;
        min_neg = {1'b1, {(W-1){1'b0}}};
        res = '0;
        case (f3)
            F3_MUL:    begin p = ua * ub; res = p[W-1:0];     end
            F3_MULH:   begin p = sa * sb; res = p[2*W-1:W];   end
            F3_MULHSU: begin p = sa * ub; res = p[2*W-1:W];   end
            F3_MULHU:  begin p = ua * ub; res = p[2*W-1:W];   end
            F3_DIV, F3_REM: begin
                if (b == '0) res = (f3 == F3_DIV) ? '1 : a;
                else if (a == min_neg && b == '1) res = (f3 == F3_DIV) ? min_neg : '0;
                else begin
                    qs = sa64 / sb64;
                    rs = sa64 % sb64;
                    res = (f3 == F3_DIV) ? qs : rs;
                end
            end
            default: begin
                if (b == '0) res = (f3 == F3_DIVU) ? '1 : a;
                else res = (f3 == F3_DIVU) ? a / b : a % b;
            end
        endcase
        return res;
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (f3[2] && (b == '0 || (!f3[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1)))
            return LAT_SPECIAL;
        return LAT_FULL;
    endfunction

    // Scoreboard side: every o_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", W'(done), '0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                check(mon_tag, result, mon_exp);
                check({mon_tag, "_stall_in_done"}, W'(stall), '0);
                check({mon_tag, "_busy_in_done"}, W'(busy), '0);
            end
        end
    end

    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int lat);
        int n;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b1;
        func3 = f3;
        word  = w;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        check({tag, "_busy_after_start"}, W'(busy), W'(lat > 0));
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        n = 0;
        while (!done && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(lat));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        word  = 1'b0;
        func3 = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check("reset_done", W'(done), '0);
        check("reset_busy", W'(busy), '0);
        check("reset_stall", W'(stall), '0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7_x_m3", F3_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, LAT_FULL);
        run_op("mulhu_max", F3_MULHU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL);
        run_op("mulhsu_m1_x_2", F3_MULHSU, 1'b0, '1, 64'd2, '1, LAT_FULL);
        run_op("div_m7_2", F3_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL);
        run_op("rem_m7_2", F3_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, LAT_FULL);
        run_op("divu_100_7", F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, LAT_FULL);
        run_op("remu_100_7", F3_REMU, 1'b0, 64'd100, 64'd7, 64'd2, LAT_FULL);

        run_op("div_by_zero", F3_DIV, 1'b0, 64'd5, '0, '1, LAT_SPECIAL);
        run_op("rem_by_zero", F3_REM, 1'b0, 64'd5, '0, 64'd5, LAT_SPECIAL);
        run_op("divu_by_zero", F3_DIVU, 1'b0, 64'd5, '0, '1, LAT_SPECIAL);
        run_op("div_overflow", F3_DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, LAT_SPECIAL);
        run_op("rem_overflow", F3_REM, 1'b0, 64'h8000_0000_0000_0000, '1, '0, LAT_SPECIAL);

        for (int i = 0; i < 16; i++) begin
            rf3 = 3'(i % 8);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (i >= 8) rb = rb >> $urandom_range(60, 8);
            if (rb == '0) rb = 64'd1;
            run_op($sformatf("rand%0d_f3_%0d", i, rf3), rf3, 1'b0, ra, rb,
                   model(rf3, ra, rb), model_lat(rf3, ra, rb));
        end

        // Flush at CALC step 10: no o_done, result untouched.
        prev_result = result;
        @(negedge clk);
        start = 1'b1;
        func3 = F3_DIVU;
        word  = 1'b0;
        rs1   = 64'd1000;
        rs2   = 64'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("flush_busy", W'(busy), '0);
        check("flush_done", W'(done), '0);
        check("flush_result_kept", result, prev_result);
        @(negedge clk);
        flush = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("flush_stays_idle", W'(busy), '0);

        // Flush together with start in IDLE: nothing is launched.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        func3 = F3_DIVU;
        rs1   = 64'd9;
        rs2   = 64'd3;
        @(posedge clk);
        #1;
        check("flush_with_start_busy", W'(busy), '0);
        check("flush_with_start_done", W'(done), '0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;

        // Reset at CALC step 20.
        @(negedge clk);
        start = 1'b1;
        func3 = F3_MULHU;
        rs1   = '1;
        rs2   = '1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midop_reset_result", result, '0);
        check("midop_reset_done", W'(done), '0);
        check("midop_reset_busy", W'(busy), '0);
        check("midop_reset_stall", W'(stall), '0);
        @(negedge clk);
        rst = 1'b0;
        run_op("divu_after_reset", F3_DIVU, 1'b0, 64'd1000000, 64'd7, 64'd142857, LAT_FULL);

`ifdef MULDIV_WORD_OPS_EN
        run_op("divw_overflow", F3_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, '1,
               64'hFFFF_FFFF_8000_0000, LAT_SPECIAL);
        run_op("mulw_3_x_2", F3_MUL, 1'b1, 64'h1_0000_0003, 64'd2, 64'd6, LAT_WORD);
        run_op("divw_m7_2", F3_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, LAT_WORD);
        run_op("remuw_100_7", F3_REMU, 1'b1, 64'hABCD_0000_0000_0064, 64'd7, 64'd2, LAT_WORD);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_empty", W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
